regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised register file for the pipelined datapath, with an integrated per-register scoreboard.
- Two combinational read ports and one synchronous write (writeback) port; register 0 reads as zero and ignores writes.
- The scoreboard marks a destination busy when an instruction issues and clears it on writeback, so decode can see RAW/WAW hazards.
- Sits between decode (reads, issue) and writeback (write).

Parameters:
- DATA_W, 8, register width in bits.
- ADDR_W, 3, register index width; NREGS = 2**ADDR_W.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- rr1  input  ADDR_W  read port 1 index.
- rr2  input  ADDR_W  read port 2 index.
- rd1  output  DATA_W  read port 1 data.
- rd2  output  DATA_W  read port 2 data.
- wr_en  input  1  writeback strobe.
- wr_addr  input  ADDR_W  writeback index.
- wr_data  input  DATA_W  writeback data.
- iss_valid  input  1  instruction issuing with a destination register.
- iss_rd  input  ADDR_W  destination of the issuing instruction.
- hazard  output  1  rr1/rr2/iss_rd is busy; decode must stall.
- busy_vec  output  NREGS  scoreboard bits, bit i = register i pending.
- err_waw  output  1  sticky: issue accepted to a busy register.

Behaviour:
- Reset (async, rst=1):
  - All registers clear to 0; all busy bits clear.
  - err_waw clears to 0; hazard reads 0.
  - rd1/rd2 read 0 for every index.
  - Reset mid-operation discards all pending writes and issues.
- Read ports: combinational, zero cycle latency. An index of 0 always returns 0.
- Write: on posedge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. Visible on the read ports the cycle after the edge. wr_addr=0 is a no-op.
- Scoreboard, per register i != 0, evaluated at posedge:
  - set if iss_valid && iss_rd==i;
  - else clear if wr_en && wr_addr==i;
  - else hold.
  - Simultaneous issue and writeback to the same register: the set wins and the register stays busy (new producer). The write data is still stored.
  - busy[0] is constant 0. iss_rd=0 never sets busy.
- hazard (combinational) = (busy[rr1] && rr1!=0) || (busy[rr2] && rr2!=0) || (iss_valid && busy[iss_rd] && iss_rd!=0).
  - Same-cycle writeback clear is NOT reflected, unless BYPASS_EN is defined.
- err_waw: set at posedge when iss_valid && iss_rd!=0 && busy[iss_rd] && !(wr_en && wr_addr==iss_rd). Cleared only by rst.
- Writeback to a non-busy register: data written, busy unchanged, no error.
- All indices lie in range by construction (NREGS = 2**ADDR_W); there is no out-of-range case.

Optional Feature:
- Macro RF_BYPASS_EN.
- When defined:
  - Read port n returns wr_data when wr_en && wr_addr==rrn && rrn!=0 (write-through forwarding in the same cycle).
  - For hazard computation, busy[i] is masked when wr_en && wr_addr==i.
- When undefined: reads return only stored state; a dependent instruction stalls one extra cycle after writeback.

Decomposition:
- Package regfile_pkg holds:
  - DATA_W/ADDR_W default constants;
  - typedefs reg_idx_t (logic [ADDR_W-1:0]) and reg_data_t;
  - localparam REG_ZERO = 0.
- One sub-module, regfile_scoreboard: busy bits, err_waw, and hazard logic. The top holds the storage array and read muxes.

Test Plan:
- Reset then read all indices -> rd1=rd2=0, busy_vec=0, hazard=0, err_waw=0.
- Write r3=8'hA5 (wr_en=1); next cycle rr1=3 -> rd1=8'hA5. Write r0=8'hFF; rr2=0 -> rd2=0.
- Issue iss_rd=5; next cycle rr1=5 -> hazard=1, busy_vec[5]=1. Writeback r5=8'h3C -> next cycle hazard=0 and rd1=8'h3C. With RF_BYPASS_EN, hazard=0 and rd1=8'h3C in the writeback cycle itself.
- Same edge: iss_valid, iss_rd=2 and wr_en, wr_addr=2, wr_data=8'h11 -> busy_vec[2]=1, reg2=8'h11, err_waw=0.
- Issue r4, then issue r4 again without writeback -> err_waw=1 and stays 1 across later writebacks until rst.
- Assert rst asynchronously between edges while busy_vec=8'h2C -> busy_vec=0 and all reads 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and types for the register file with
//               integrated scoreboard (regfile_sb). Holds the default widths,
//               the index/data typedefs and the hard-wired zero register index.
// Options     : none here; see regfile_sb for the RF_BYPASS_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    // Default geometry: 8 registers of 8 bits.
    localparam int RF_DATA_W = 8;
    localparam int RF_ADDR_W = 3;

    // Index of the architectural zero register (reads 0, ignores writes).
    localparam int REG_ZERO = 0;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;
    typedef logic [RF_DATA_W-1:0] reg_data_t;

    // Number of registers addressable with an index of the given width.
    function automatic int rf_nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register busy tracking for the register file. An issuing
//               instruction marks its destination busy; writeback clears it.
//               Produces the decode stall (hazard) and a sticky WAW error.
// Ports       : clk, rst (async, active high)
//               rr1, rr2        - read indices checked for RAW hazards
//               wr_en, wr_addr  - writeback, clears busy
//               iss_valid, iss_rd - issue, sets busy
//               hazard          - decode must stall
//               busy_vec        - bit i = register i pending
//               err_waw         - sticky: issue accepted to a busy register
// Options     : RF_BYPASS_EN - a same-cycle writeback masks its busy bit when
//               computing hazard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int ADDR_W = RF_ADDR_W,
    localparam int NREGS  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              hazard,
    output logic [NREGS-1:0]  busy_vec,
    output logic              err_waw
);

    localparam logic [ADDR_W-1:0] c_ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_set;
    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_busy_haz;
    logic             r_err;
    logic             w_waw;

    // One-hot set/clear masks; register 0 can never become busy.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (iss_valid) begin
            w_set[iss_rd] = 1'b1;
        end
        if (wr_en) begin
            w_clr[wr_addr] = 1'b1;
        end
        w_set[REG_ZERO] = 1'b0;
        w_clr[REG_ZERO] = 1'b0;
    end

    // Set has priority over clear: an issue in the writeback cycle of the same
    // register is a new producer, so the register stays busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    // A writeback retiring the old producer on the same edge makes the
    // re-issue legal, so it is not flagged.
    assign w_waw = iss_valid && (iss_rd != c_ZERO_IDX) && r_busy[iss_rd]
                   && !(wr_en && (wr_addr == iss_rd));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_waw) begin
            r_err <= 1'b1;
        end
    end

`ifdef RF_BYPASS_EN
    // The value being written back is forwarded on the read ports, so its
    // consumer need not wait for the busy bit to drop.
    assign w_busy_haz = r_busy & ~w_clr;
`else
    assign w_busy_haz = r_busy;
`endif

    assign hazard = (w_busy_haz[rr1] && (rr1 != c_ZERO_IDX))
                 || (w_busy_haz[rr2] && (rr2 != c_ZERO_IDX))
                 || (iss_valid && w_busy_haz[iss_rd] && (iss_rd != c_ZERO_IDX));

    assign busy_vec = r_busy;
    assign err_waw  = r_err;

endmodule : regfile_scoreboard
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Register file with two combinational read ports, one
//               synchronous writeback port and an integrated scoreboard.
//               Register 0 reads as zero and ignores writes.
// Ports       : clk, rst (async, active high)
//               rr1/rd1, rr2/rd2         - read ports (zero latency)
//               wr_en, wr_addr, wr_data  - writeback port
//               iss_valid, iss_rd        - issue with destination register
//               hazard, busy_vec, err_waw - scoreboard status
// Options     : RF_BYPASS_EN - forward wr_data to a read port addressing the
//               register being written in the same cycle, and let that
//               writeback lift the hazard immediately.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int DATA_W = RF_DATA_W,
    parameter  int ADDR_W = RF_ADDR_W,
    localparam int NREGS  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rr1,
    input  logic [ADDR_W-1:0] rr2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              hazard,
    output logic [NREGS-1:0]  busy_vec,
    output logic              err_waw
);

    localparam logic [ADDR_W-1:0] c_ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    // Storage. Entry 0 is never written, and the read muxes ignore it anyway.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wr_en && (wr_addr != c_ZERO_IDX)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (rr1 != c_ZERO_IDX) begin
            w_rd1 = r_regs[rr1];
        end
        if (rr2 != c_ZERO_IDX) begin
            w_rd2 = r_regs[rr2];
        end
`ifdef RF_BYPASS_EN
        // Write-through: the register being written back reads its new value.
        if (wr_en && (wr_addr == rr1) && (rr1 != c_ZERO_IDX)) begin
            w_rd1 = wr_data;
        end
        if (wr_en && (wr_addr == rr2) && (rr2 != c_ZERO_IDX)) begin
            w_rd2 = wr_data;
        end
`endif
    end

    assign rd1 = w_rd1;
    assign rd2 = w_rd2;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .rr1       (rr1),
        .rr2       (rr2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .hazard    (hazard),
        .busy_vec  (busy_vec),
        .err_waw   (err_waw)
    );

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_sb
// Description : Self-checking bench for regfile_sb. A table of per-cycle
//               input/expected-output records drives the reads, writes and
//               scoreboard cases; hand-written sequences cover the reset
//               state and an asynchronous reset taken between clock edges.
//               Expected values follow the RF_BYPASS_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

`ifdef RF_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] rr1 = '0;
    logic [2:0] rr2 = '0;
    logic [7:0] rd1;
    logic [7:0] rd2;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       iss_valid = 1'b0;
    logic [2:0] iss_rd = '0;
    logic       hazard;
    logic [7:0] busy_vec;
    logic       err_waw;

    int n_checks = 0;
    int n_pass   = 0;

    regfile_sb #(
        .DATA_W (8),
        .ADDR_W (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rr1       (rr1),
        .rr2       (rr2),
        .rd1       (rd1),
        .rd2       (rd2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .hazard    (hazard),
        .busy_vec  (busy_vec),
        .err_waw   (err_waw)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       iss_valid;
        logic [2:0] iss_rd;
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic [7:0] e_rd1;
        logic [7:0] e_rd2;
        logic [7:0] e_busy;
        logic       e_haz;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                input logic iv, input logic [2:0] ir,
                                input logic [2:0] a1, input logic [2:0] a2,
                                input logic [7:0] e1, input logic [7:0] e2,
                                input logic [7:0] eb, input logic eh, input logic ee);
        vec_t v;
        v.wr_en = we;  v.wr_addr = wa; v.wr_data = wd;
        v.iss_valid = iv; v.iss_rd = ir;
        v.rr1 = a1; v.rr2 = a2;
        v.e_rd1 = e1; v.e_rd2 = e2; v.e_busy = eb; v.e_haz = eh; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Guard against a stuck run.
    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Each row: inputs held for one cycle, outputs sampled before the edge.
        //            we wa  wd     iv ir  rr1 rr2 rd1                        rd2    busy   haz               err
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 7, 8'h00,                     8'h00, 8'h00, 1'b0,             0));
        vecs.push_back(mk(1, 3, 8'hA5, 0, 0, 1, 3, 8'h00,                     c_BYP ? 8'hA5 : 8'h00, 8'h00, 1'b0, 0));
        vecs.push_back(mk(1, 0, 8'hFF, 0, 0, 3, 0, 8'hA5,                     8'h00, 8'h00, 1'b0,             0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 5, 0, 0, 8'h00,                     8'h00, 8'h00, 1'b0,             0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 5, 3, 8'h00,                     8'hA5, 8'h20, 1'b1,             0));
        vecs.push_back(mk(1, 5, 8'h3C, 0, 0, 5, 3, c_BYP ? 8'h3C : 8'h00,     8'hA5, 8'h20, !c_BYP,           0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 5, 0, 8'h3C,                     8'h00, 8'h00, 1'b0,             0));
        vecs.push_back(mk(1, 2, 8'h11, 1, 2, 2, 5, c_BYP ? 8'h11 : 8'h00,     8'h3C, 8'h00, 1'b0,             0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 2, 0, 8'h11,                     8'h00, 8'h04, 1'b1,             0));
        vecs.push_back(mk(1, 2, 8'h22, 0, 0, 2, 0, c_BYP ? 8'h22 : 8'h11,     8'h00, 8'h04, !c_BYP,           0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 6, 2, 0, 8'h22,                     8'h00, 8'h00, 1'b0,             0));
        vecs.push_back(mk(1, 6, 8'h66, 1, 6, 6, 0, c_BYP ? 8'h66 : 8'h00,     8'h00, 8'h40, !c_BYP,           0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 6, 0, 8'h66,                     8'h00, 8'h40, 1'b1,             0));
        vecs.push_back(mk(1, 6, 8'h67, 0, 0, 6, 0, c_BYP ? 8'h67 : 8'h66,     8'h00, 8'h40, !c_BYP,           0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 4, 6, 1, 8'h67,                     8'h00, 8'h00, 1'b0,             0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 4, 0, 0, 8'h00,                     8'h00, 8'h10, 1'b1,             0));
        vecs.push_back(mk(1, 4, 8'h44, 0, 0, 4, 0, c_BYP ? 8'h44 : 8'h00,     8'h00, 8'h10, !c_BYP,           1));
        vecs.push_back(mk(1, 1, 8'h01, 0, 0, 4, 2, 8'h44,                     8'h22, 8'h00, 1'b0,             1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 1, 7, 8'h01,                     8'h00, 8'h00, 1'b0,             1));

        // Reset state: every index reads zero, scoreboard idle.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rr1 = 3'(i);
            rr2 = 3'(7 - i);
            #0.5;
            chk($sformatf("reset read idx %0d", i), {rd1, rd2}, 32'h0);
        end
        chk("reset busy_vec", busy_vec, 32'h0);
        chk("reset hazard", hazard, 32'h0);
        chk("reset err_waw", err_waw, 32'h0);

        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) begin
            wr_en     = vecs[i].wr_en;
            wr_addr   = vecs[i].wr_addr;
            wr_data   = vecs[i].wr_data;
            iss_valid = vecs[i].iss_valid;
            iss_rd    = vecs[i].iss_rd;
            rr1       = vecs[i].rr1;
            rr2       = vecs[i].rr2;
            @(negedge clk);
            chk($sformatf("v%0d rd1", i), rd1, vecs[i].e_rd1);
            chk($sformatf("v%0d rd2", i), rd2, vecs[i].e_rd2);
            chk($sformatf("v%0d busy_vec", i), busy_vec, vecs[i].e_busy);
            chk($sformatf("v%0d hazard", i), hazard, vecs[i].e_haz);
            chk($sformatf("v%0d err_waw", i), err_waw, vecs[i].e_err);
            @(posedge clk);
            #1;
        end

        // Build busy_vec = 8'h2C (registers 2, 3, 5), then reset mid-cycle.
        wr_en = 1'b0;
        iss_valid = 1'b1;
        iss_rd = 3'd2;
        @(posedge clk); #1;
        iss_rd = 3'd3;
        @(posedge clk); #1;
        iss_rd = 3'd5;
        @(posedge clk); #1;
        iss_valid = 1'b0;
        rr1 = 3'd3;
        rr2 = 3'd6;
        #1;
        chk("pre-rst busy_vec", busy_vec, 32'h2C);
        chk("pre-rst rd1", rd1, 32'hA5);
        chk("pre-rst rd2", rd2, 32'h67);
        chk("pre-rst err_waw", err_waw, 32'h1);
        #1;
        rst = 1'b1;
        #1;
        chk("async rst busy_vec", busy_vec, 32'h0);
        chk("async rst rd1", rd1, 32'h0);
        chk("async rst rd2", rd2, 32'h0);
        chk("async rst err_waw", err_waw, 32'h0);
        chk("async rst hazard", hazard, 32'h0);

        // Normal operation resumes after reset release.
        @(posedge clk); #1;
        rst = 1'b0;
        wr_en = 1'b1;
        wr_addr = 3'd7;
        wr_data = 8'h5A;
        @(posedge clk); #1;
        wr_en = 1'b0;
        rr1 = 3'd7;
        #1;
        chk("post-rst write rd1", rd1, 32'h5A);
        chk("post-rst busy_vec", busy_vec, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
